// File: rtl/spi_flash_wb_reader_pkg.sv
// Shared types and constants for the SPI-flash Wishbone reader.
package spi_flash_pkg;

  // Default register map of the downstream WB-to-SPI master
  localparam logic [7:0] DEF_READ_CMD    = 8'h03;
  localparam logic [7:0] DEF_CONFIG_ADDR = 8'h01;
  localparam logic [7:0] DEF_DATA_ADDR   = 8'h02;
  localparam logic [7:0] DEF_INJECT_ADDR = 8'h03;

  // Config register values: bit0 = CS level, bit1 = discard RX
  localparam logic [7:0] CFG_CS_LOW  = 8'h00;
  localparam logic [7:0] CFG_CS_HIGH = 8'h01;

  typedef enum logic [2:0] {
    IDLE, CS_LOW, CMD, DRAIN, INJECT, READ, CS_HIGH
  } state_t;

  typedef enum logic [1:0] {
    PH_IDLE, PH_ISSUE, PH_ACK
  } wb_phase_t;

  // Command/address byte sent at position idx of the 4-byte READ header
  function automatic logic [7:0] cmd_byte(input logic [1:0] idx,
                                          input logic [7:0] cmd,
                                          input logic [23:0] addr);
    logic [7:0] b;
    case (idx)
      2'd0:    b = cmd;
      2'd1:    b = addr[23:16];
      2'd2:    b = addr[15:8];
      default: b = addr[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/spi_flash_wb_reader_if.sv
// Pipelined Wishbone bus between the reader and the WB-to-SPI master.
interface spi_flash_wb_reader_if;
  logic [7:0] addr;
  logic [7:0] dat_m2s;
  logic [7:0] dat_s2m;
  logic       we;
  logic       sel;
  logic       stb;
  logic       cyc;
  logic       ack;
  logic       stall;

  modport master (
    output addr, dat_m2s, we, sel, stb, cyc,
    input  dat_s2m, ack, stall
  );

  modport slave (
    input  addr, dat_m2s, we, sel, stb, cyc,
    output dat_s2m, ack, stall
  );
endinterface

// File: rtl/spi_flash_wb_reader_wb_single_master.sv
// Single-outstanding pipelined Wishbone op engine: ISSUE then ACK phase.
// done/rdata are combinational on ack so the caller can advance on the
// same edge the engine returns to idle.
module wb_single_master
  import spi_flash_pkg::*;
(
  input  logic       clk,
  input  logic       areset,
  input  logic       op_valid,
  input  logic [7:0] op_addr,
  input  logic [7:0] op_dat,
  input  logic       op_we,
  output logic       op_idle,
  output logic       done,
  output logic [7:0] rdata,
  output logic [7:0] wb_addr,
  output logic [7:0] wb_dat_m2s,
  output logic       wb_we,
  output logic       wb_stb,
  input  logic [7:0] wb_dat_s2m,
  input  logic       wb_ack,
  input  logic       wb_stall
);

  wb_phase_t phase;

  assign op_idle = (phase == PH_IDLE);
  assign done    = (phase == PH_ACK) && wb_ack;
  assign rdata   = wb_dat_s2m;

  // Latch an op, hold stb until the slave stops stalling, then wait for ack
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      phase      <= PH_IDLE;
      wb_stb     <= 1'b0;
      wb_addr    <= 8'h00;
      wb_dat_m2s <= 8'h00;
      wb_we      <= 1'b0;
    end else begin
      case (phase)
        PH_IDLE: begin
          if (op_valid) begin
            wb_addr    <= op_addr;
            wb_dat_m2s <= op_dat;
            wb_we      <= op_we;
            wb_stb     <= 1'b1;
            phase      <= PH_ISSUE;
          end
        end
        PH_ISSUE: begin
          if (!wb_stall) begin
            wb_stb <= 1'b0;
            phase  <= PH_ACK;
          end
        end
        PH_ACK: begin
          if (wb_ack) phase <= PH_IDLE;
        end
        default: phase <= PH_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/spi_flash_wb_reader.sv
// SPI-flash READ (0x03) sequencer driving a WB-to-SPI master; returns the
// flash bytes as an AXI-Stream with tlast on the final byte.
module spi_flash_wb_reader
  import spi_flash_pkg::*;
#(
  parameter logic [7:0] READ_CMD    = DEF_READ_CMD,
  parameter logic [7:0] CONFIG_ADDR = DEF_CONFIG_ADDR,
  parameter logic [7:0] DATA_ADDR   = DEF_DATA_ADDR,
  parameter logic [7:0] INJECT_ADDR = DEF_INJECT_ADDR
) (
  input  logic                          clk,
  input  logic                          areset,
  input  logic                          s_axis_req_tvalid,
  output logic                          s_axis_req_tready,
  input  logic [31:0]                   s_axis_req_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [7:0]                    m_axis_tdata,
  output logic                          m_axis_tlast,
  spi_flash_wb_reader_if.master         m_wb,
  output logic                          busy
);

  state_t      state;
  logic [1:0]  idx;
  logic [7:0]  rem;
  logic        cyc_q;
  logic [23:0] faddr;
  logic [7:0]  flen;

  logic        op_valid;
  logic [7:0]  op_addr;
  logic [7:0]  op_dat;
  logic        op_we;
  logic        op_idle;
  logic        done;
  logic [7:0]  rdata;

  assign s_axis_req_tready = (state == IDLE);
  assign busy              = (state != IDLE);
  assign m_wb.sel          = 1'b1;
  assign m_wb.cyc          = cyc_q;

  wb_single_master u_wb (
    .clk        (clk),
    .areset     (areset),
    .op_valid   (op_valid),
    .op_addr    (op_addr),
    .op_dat     (op_dat),
    .op_we      (op_we),
    .op_idle    (op_idle),
    .done       (done),
    .rdata      (rdata),
    .wb_addr    (m_wb.addr),
    .wb_dat_m2s (m_wb.dat_m2s),
    .wb_we      (m_wb.we),
    .wb_stb     (m_wb.stb),
    .wb_dat_s2m (m_wb.dat_s2m),
    .wb_ack     (m_wb.ack),
    .wb_stall   (m_wb.stall)
  );

  // Pick the WB op for the current sequencer position; reads wait for an empty output register
  always_comb begin
    op_valid = 1'b0;
    op_addr  = DATA_ADDR;
    op_dat   = 8'h00;
    op_we    = 1'b0;
    case (state)
      CS_LOW: begin
        op_valid = op_idle;
        op_addr  = CONFIG_ADDR;
        op_dat   = CFG_CS_LOW;
        op_we    = 1'b1;
      end
      CMD: begin
        op_valid = op_idle;
        op_dat   = cmd_byte(idx, READ_CMD, faddr);
        op_we    = 1'b1;
      end
      DRAIN: op_valid = op_idle;
      INJECT: begin
        op_valid = op_idle;
        op_addr  = INJECT_ADDR;
        op_dat   = flen;
        op_we    = 1'b1;
      end
      READ: op_valid = op_idle && (rem != 8'd0) && !m_axis_tvalid;
      CS_HIGH: begin
        op_valid = op_idle;
        op_addr  = CONFIG_ADDR;
        op_dat   = CFG_CS_HIGH;
        op_we    = 1'b1;
      end
      default: op_valid = 1'b0;
    endcase
  end

  // Request address/length capture on the accept handshake
  always_ff @(posedge clk) begin
    if (state == IDLE && s_axis_req_tvalid) begin
      faddr <= s_axis_req_tdata[23:0];
      flen  <= s_axis_req_tdata[31:24];
    end
  end

  // Transaction sequencer: CS low, header, drain, inject, read, CS high
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state <= IDLE;
      idx   <= 2'd0;
      rem   <= 8'd0;
      cyc_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (s_axis_req_tvalid) begin
            rem <= s_axis_req_tdata[31:24];
            idx <= 2'd0;
            if (s_axis_req_tdata[31:24] != 8'd0) state <= CS_LOW;
          end
        end
        CS_LOW: begin
          if (op_valid) cyc_q <= 1'b1;
          if (done) state <= CMD;
        end
        CMD: begin
          if (done) begin
            idx <= idx + 2'd1;
            if (idx == 2'd3) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (done) begin
            idx <= idx + 2'd1;
            if (idx == 2'd3) state <= INJECT;
          end
        end
        INJECT: begin
          if (done) state <= READ;
        end
        READ: begin
          if (done) rem <= rem - 8'd1;
          else if (rem == 8'd0 && !m_axis_tvalid) state <= CS_HIGH;
        end
        CS_HIGH: begin
          if (done) begin
            cyc_q <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output byte register: loads on a READ ack, clears when the consumer takes it
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= 8'h00;
      m_axis_tlast  <= 1'b0;
    end else if (state == READ && done) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= rdata;
      m_axis_tlast  <= (rem == 8'd1);
    end else if (m_axis_tvalid && m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule
